ddr4_cmd_monitor: RTL and testbench

DDR4_CMD_MONITOR -- requirements
Module: ddr4_cmd_monitor

---
 rtl/ddr4_mon_pkg.sv | 50 +++++
 rtl/ddr4_bank_tracker.sv | 65 ++++++
 rtl/ddr4_cmd_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_ddr4_cmd_monitor.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_mon_pkg
// Brief    : Shared command, bank-state and error-code definitions for the
//            DDR4 command monitor.
// Revision : 1.0 - initial release
// ============================================================================
package ddr4_mon_pkg;

    // Decoded command seen on the bus in one ddr_ck cycle
    typedef enum logic [3:0] {
        CMD_NONE = 4'd0,
        CMD_ACT  = 4'd1,
        CMD_MRS  = 4'd2,
        CMD_REF  = 4'd3,
        CMD_PRE  = 4'd4,
        CMD_PREA = 4'd5,
        CMD_WR   = 4'd6,
        CMD_RD   = 4'd7,
        CMD_ZQC  = 4'd8,
        CMD_NOP  = 4'd9,
        CMD_RSVD = 4'd10
    } cmd_e;

    // Per-bank open/closed state
    typedef enum logic [0:0] {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_e;

    // Error codes; a lower value wins when several fire in one cycle
    localparam logic [3:0] c_ERR_NONE      = 4'd0;
    localparam logic [3:0] c_ERR_MULTI_CS  = 4'd1;
    localparam logic [3:0] c_ERR_RSVD      = 4'd2;
    localparam logic [3:0] c_ERR_ACT_OPEN  = 4'd3;
    localparam logic [3:0] c_ERR_ACT_TRP   = 4'd4;
    localparam logic [3:0] c_ERR_RDWR_IDLE = 4'd5;
    localparam logic [3:0] c_ERR_RDWR_TRCD = 4'd6;
    localparam logic [3:0] c_ERR_PRE_TRAS  = 4'd7;
    localparam logic [3:0] c_ERR_REF_OPEN  = 4'd8;

    // Largest of three timing parameters, used to size the bank timers
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr4_bank_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_bank_tracker
// Brief    : Open/closed state and elapsed-time tracking for one DDR4 bank,
//            with the timing/state violation flags for that bank.
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_bank_tracker
    import ddr4_mon_pkg::*;
#(
    parameter int T_RCD = 16,
    parameter int T_RP  = 16,
    parameter int T_RAS = 39,
    parameter int TMR_W = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_act,
    input  logic i_pre,
    input  logic i_rdwr,
    input  logic i_auto_pre,
    output logic o_open,
    output logic o_err_act_open,
    output logic o_err_act_trp,
    output logic o_err_rdwr_idle,
    output logic o_err_rdwr_trcd,
    output logic o_err_pre_tras
);

    // The timer reads k-1 on the k-th edge after the last restart, so a
    // command k cycles after the event violates T when timer < T-1.
    localparam logic [TMR_W-1:0] c_RCD_LIM = TMR_W'(T_RCD - 1);
    localparam logic [TMR_W-1:0] c_RP_LIM  = TMR_W'(T_RP - 1);
    localparam logic [TMR_W-1:0] c_RAS_LIM = TMR_W'(T_RAS - 1);

    bank_state_e      r_state;
    logic [TMR_W-1:0] r_tmr;
    logic             w_active;

    assign w_active        = (r_state == BANK_ACTIVE);
    assign o_open          = w_active;
    assign o_err_act_open  = i_act  &  w_active;
    assign o_err_act_trp   = i_act  & ~w_active & (r_tmr < c_RP_LIM);
    assign o_err_rdwr_idle = i_rdwr & ~w_active;
    assign o_err_rdwr_trcd = i_rdwr &  w_active & (r_tmr < c_RCD_LIM);
    assign o_err_pre_tras  = i_pre  &  w_active & (r_tmr < c_RAS_LIM);

    // Bank state and saturating timer; PRE to an idle bank leaves the timer running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BANK_IDLE;
            r_tmr   <= '1;
        end else if (i_act) begin
            r_state <= BANK_ACTIVE;
            r_tmr   <= '0;
        end else if ((i_pre && w_active) || (i_rdwr && i_auto_pre)) begin
            r_state <= BANK_IDLE;
            r_tmr   <= '0;
        end else if (r_tmr != '1) begin
            r_tmr <= r_tmr + TMR_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr4_cmd_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_cmd_monitor
// Brief    : Passive DDR4 command-bus monitor: decodes commands, tracks bank
//            state per rank/bank, flags protocol/timing errors and counts
//            ACT/RD/WR/REF commands.
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_cmd_monitor
    import ddr4_mon_pkg::*;
#(
    parameter int NUM_RANKS = 1,
    parameter int T_RCD     = 16,
    parameter int T_RP      = 16,
    parameter int T_RAS     = 39,
    parameter int CNT_W     = 32
) (
    input  logic                    ddr_ck,
    input  logic                    ddr_rst,
    input  logic [NUM_RANKS-1:0]    ddr_csb,
    input  logic                    ddr_cke,
    input  logic                    ddr_actn,
    input  logic [1:0]              ddr_bg,
    input  logic [1:0]              ddr_ba,
    input  logic [17:0]             ddr_addr,
    input  logic                    mon_en,
    input  logic                    err_clr,
    output logic [NUM_RANKS*16-1:0] bank_open,
    output logic                    err_valid,
    output logic [3:0]              err_code,
    output logic [1:0]              err_rank,
    output logic [3:0]              err_bank,
    output logic [7:0]              err_sticky,
    output logic [CNT_W-1:0]        cnt_act,
    output logic [CNT_W-1:0]        cnt_rd,
    output logic [CNT_W-1:0]        cnt_wr,
    output logic [CNT_W-1:0]        cnt_ref
);

    localparam int NB    = NUM_RANKS * 16;
    localparam int TMR_W = $clog2(max3(T_RCD, T_RP, T_RAS)) + 1;

    logic [NUM_RANKS-1:0] w_csn_low;
    logic                 w_cmd_valid, w_multi_cs, w_upd;
    logic [1:0]           w_rank;
    logic [3:0]           w_bank_addr;
    cmd_e                 w_cmd;
    logic                 w_unused;

    logic [NB-1:0] w_open, w_rank_mask;
    logic [NB-1:0] w_e_act_open, w_e_act_trp, w_e_rdwr_idle, w_e_rdwr_trcd, w_e_pre_tras;
    logic [3:0]    w_tras_bank, w_err_code, w_err_bank;
    logic [7:0]    w_sticky_set;
    logic          w_err_ref_open;

    logic                 r_err_valid;
    logic [3:0]           r_err_code, r_err_bank;
    logic [1:0]           r_err_rank;
    logic [7:0]           r_err_sticky;
    logic [CNT_W-1:0]     r_cnt_act, r_cnt_rd, r_cnt_wr, r_cnt_ref;

    assign w_unused    = ^{ddr_addr[17], ddr_addr[13:11], ddr_addr[9:0]};
    assign w_csn_low   = ~ddr_csb;
    assign w_multi_cs  = |(w_csn_low & (w_csn_low - NUM_RANKS'(1)));
    assign w_cmd_valid = mon_en & ddr_cke & (|w_csn_low);
    assign w_upd       = w_cmd_valid & ~w_multi_cs;
    assign w_bank_addr = {ddr_bg, ddr_ba};

    // Addressed rank: lowest chip select driven low
    always_comb begin
        w_rank = 2'd0;
        for (int i = NUM_RANKS - 1; i >= 0; i--) begin
            if (!ddr_csb[i]) w_rank = 2'(i);
        end
    end

    // Command decode from ACT_n and the RAS_n/CAS_n/WE_n address pins
    always_comb begin
        w_cmd = CMD_NONE;
        if (w_cmd_valid) begin
            if (!ddr_actn) begin
                w_cmd = CMD_ACT;
            end else begin
                case (ddr_addr[16:14])
                    3'b000:  w_cmd = CMD_MRS;
                    3'b001:  w_cmd = CMD_REF;
                    3'b010:  w_cmd = ddr_addr[10] ? CMD_PREA : CMD_PRE;
                    3'b100:  w_cmd = CMD_WR;
                    3'b101:  w_cmd = CMD_RD;
                    3'b110:  w_cmd = CMD_ZQC;
                    3'b111:  w_cmd = CMD_NOP;
                    default: w_cmd = CMD_RSVD;
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_bank
        localparam logic [1:0] c_RANK = 2'(gi / 16);
        localparam logic [3:0] c_IDX  = 4'(gi % 16);
        logic w_in_rank, w_hit;
        assign w_in_rank       = (w_rank == c_RANK);
        assign w_hit           = w_in_rank && (w_bank_addr == c_IDX);
        assign w_rank_mask[gi] = w_in_rank;

        ddr4_bank_tracker #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS),
            .TMR_W (TMR_W)
        ) u_trk (
            .clk             (ddr_ck),
            .rst             (ddr_rst),
            .i_act           (w_upd && (w_cmd == CMD_ACT) && w_hit),
            .i_pre           (w_upd && (((w_cmd == CMD_PRE) && w_hit) || ((w_cmd == CMD_PREA) && w_in_rank))),
            .i_rdwr          (w_upd && ((w_cmd == CMD_RD) || (w_cmd == CMD_WR)) && w_hit),
            .i_auto_pre      (ddr_addr[10]),
            .o_open          (w_open[gi]),
            .o_err_act_open  (w_e_act_open[gi]),
            .o_err_act_trp   (w_e_act_trp[gi]),
            .o_err_rdwr_idle (w_e_rdwr_idle[gi]),
            .o_err_rdwr_trcd (w_e_rdwr_trcd[gi]),
            .o_err_pre_tras  (w_e_pre_tras[gi])
        );
    end

    assign bank_open      = w_open;
    assign w_err_ref_open = w_upd && ((w_cmd == CMD_REF) || (w_cmd == CMD_MRS)) && (|(w_open & w_rank_mask));

    // Lowest bank index in violation of T_RAS (several can hit on PREA)
    always_comb begin
        w_tras_bank = 4'd0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (w_e_pre_tras[i]) w_tras_bank = 4'(i % 16);
        end
    end

    // Priority encode: the lowest error code present this cycle is reported
    always_comb begin
        w_err_code = c_ERR_NONE;
        w_err_bank = w_bank_addr;
        if (w_cmd_valid && w_multi_cs)     w_err_code = c_ERR_MULTI_CS;
        else if (w_upd && (w_cmd == CMD_RSVD)) w_err_code = c_ERR_RSVD;
        else if (|w_e_act_open)            w_err_code = c_ERR_ACT_OPEN;
        else if (|w_e_act_trp)             w_err_code = c_ERR_ACT_TRP;
        else if (|w_e_rdwr_idle)           w_err_code = c_ERR_RDWR_IDLE;
        else if (|w_e_rdwr_trcd)           w_err_code = c_ERR_RDWR_TRCD;
        else if (|w_e_pre_tras) begin
            w_err_code = c_ERR_PRE_TRAS;
            w_err_bank = w_tras_bank;
        end else if (w_err_ref_open)       w_err_code = c_ERR_REF_OPEN;
    end

    assign w_sticky_set = (w_err_code == c_ERR_NONE) ? 8'h00 : (8'h01 << (w_err_code - 4'd1));

    // Error report registers; a same-cycle error overrides err_clr
    always_ff @(posedge ddr_ck or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_err_valid  <= 1'b0;
            r_err_code   <= 4'd0;
            r_err_rank   <= 2'd0;
            r_err_bank   <= 4'd0;
            r_err_sticky <= 8'h00;
        end else begin
            r_err_valid <= (w_err_code != c_ERR_NONE);
            if (w_err_code != c_ERR_NONE) begin
                r_err_code <= w_err_code;
                r_err_rank <= w_rank;
                r_err_bank <= w_err_bank;
            end
            r_err_sticky <= (err_clr ? 8'h00 : r_err_sticky) | w_sticky_set;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Saturating command counters; multi-CS cycles are not counted
    always_ff @(posedge ddr_ck or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_cnt_act <= '0;
            r_cnt_rd  <= '0;
            r_cnt_wr  <= '0;
            r_cnt_ref <= '0;
        end else begin
            r_cnt_act <= sat_inc(r_cnt_act, w_upd && (w_cmd == CMD_ACT));
            r_cnt_rd  <= sat_inc(r_cnt_rd,  w_upd && (w_cmd == CMD_RD));
            r_cnt_wr  <= sat_inc(r_cnt_wr,  w_upd && (w_cmd == CMD_WR));
            r_cnt_ref <= sat_inc(r_cnt_ref, w_upd && (w_cmd == CMD_REF));
        end
    end

    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign err_rank   = r_err_rank;
    assign err_bank   = r_err_bank;
    assign err_sticky = r_err_sticky;
    assign cnt_act    = r_cnt_act;
    assign cnt_rd     = r_cnt_rd;
    assign cnt_wr     = r_cnt_wr;
    assign cnt_ref    = r_cnt_ref;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_cmd_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr4_cmd_monitor
// Brief    : Self-checking bench for ddr4_cmd_monitor: directed scenarios
//            followed by randomized traffic against a timestamp-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr4_cmd_monitor;

    localparam int NUM_RANKS = 2;
    localparam int T_RCD     = 4;
    localparam int T_RP      = 4;
    localparam int T_RAS     = 8;
    localparam int CNT_W     = 4;
    localparam int NB        = NUM_RANKS * 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    localparam int K_DES = 0, K_ACT = 1, K_MRS = 2, K_REF = 3, K_PRE = 4;
    localparam int K_WR  = 5, K_RD  = 6, K_ZQC = 7, K_NOP = 8, K_RSVD = 9;

    logic                 ddr_ck = 1'b0;
    logic                 ddr_rst;
    logic [NUM_RANKS-1:0] ddr_csb;
    logic                 ddr_cke, ddr_actn, mon_en, err_clr;
    logic [1:0]           ddr_bg, ddr_ba;
    logic [17:0]          ddr_addr;
    logic [NB-1:0]        bank_open;
    logic                 err_valid;
    logic [3:0]           err_code, err_bank;
    logic [1:0]           err_rank;
    logic [7:0]           err_sticky;
    logic [CNT_W-1:0]     cnt_act, cnt_rd, cnt_wr, cnt_ref;

    always #5 ddr_ck = ~ddr_ck;

    ddr4_cmd_monitor #(
        .NUM_RANKS (NUM_RANKS),
        .T_RCD     (T_RCD),
        .T_RP      (T_RP),
        .T_RAS     (T_RAS),
        .CNT_W     (CNT_W)
    ) u_dut (
        .ddr_ck     (ddr_ck),
        .ddr_rst    (ddr_rst),
        .ddr_csb    (ddr_csb),
        .ddr_cke    (ddr_cke),
        .ddr_actn   (ddr_actn),
        .ddr_bg     (ddr_bg),
        .ddr_ba     (ddr_ba),
        .ddr_addr   (ddr_addr),
        .mon_en     (mon_en),
        .err_clr    (err_clr),
        .bank_open  (bank_open),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_rank   (err_rank),
        .err_bank   (err_bank),
        .err_sticky (err_sticky),
        .cnt_act    (cnt_act),
        .cnt_rd     (cnt_rd),
        .cnt_wr     (cnt_wr),
        .cnt_ref    (cnt_ref)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bank open flags plus the cycle number of the last
    // event that restarts the bank's timing window
    bit         m_open [NB];
    int         m_ts   [NB];
    int         m_cyc;
    bit         m_ev;
    int         m_code, m_rank, m_bank;
    logic [7:0] m_sticky;
    int         m_cnt  [4];

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_open[i] = 1'b0;
            m_ts[i]   = -1000;
        end
        m_cyc = 0; m_ev = 1'b0; m_code = 0; m_rank = 0; m_bank = 0; m_sticky = 8'h00;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endtask

    task automatic cnt_bump(input int k);
        if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
    endtask

    // Predict the effect of the currently driven inputs at the next edge
    task automatic model_step();
        int zeros, r, b, code, ebank;
        zeros = $countones(~ddr_csb);
        code  = 0;
        r     = 0;
        ebank = {ddr_bg, ddr_ba};
        for (int i = NUM_RANKS - 1; i >= 0; i--) if (!ddr_csb[i]) r = i;
        if (mon_en && ddr_cke && zeros > 0) begin
            if (zeros > 1) begin
                code = 1;
            end else begin
                b = r * 16 + ebank;
                if (!ddr_actn) begin
                    if (m_open[b]) code = 3;
                    else if (m_cyc - m_ts[b] < T_RP) code = 4;
                    m_open[b] = 1'b1;
                    m_ts[b]   = m_cyc;
                    cnt_bump(0);
                end else begin
                    case (ddr_addr[16:14])
                        3'b000, 3'b001: begin
                            for (int j = 0; j < 16; j++) if (m_open[r*16+j]) code = 8;
                            if (ddr_addr[14]) cnt_bump(3);
                        end
                        3'b010: begin
                            for (int j = 15; j >= 0; j--) begin
                                int bb;
                                bb = r * 16 + j;
                                if ((ddr_addr[10] || j == ebank) && m_open[bb]) begin
                                    if (m_cyc - m_ts[bb] < T_RAS) begin
                                        code  = 7;
                                        ebank = j;
                                    end
                                    m_open[bb] = 1'b0;
                                    m_ts[bb]   = m_cyc;
                                end
                            end
                        end
                        3'b100, 3'b101: begin
                            if (!m_open[b]) code = 5;
                            else if (m_cyc - m_ts[b] < T_RCD) code = 6;
                            if (ddr_addr[10]) begin
                                m_open[b] = 1'b0;
                                m_ts[b]   = m_cyc;
                            end
                            cnt_bump(ddr_addr[14] ? 1 : 2);
                        end
                        3'b011:  code = 2;
                        default: ;
                    endcase
                end
            end
        end
        m_ev = (code != 0);
        if (code != 0) begin
            m_code = code;
            m_rank = r;
            m_bank = ebank;
        end
        m_sticky = (err_clr ? 8'h00 : m_sticky) | ((code != 0) ? 8'(1 << (code - 1)) : 8'h00);
        m_cyc++;
    endtask

    task automatic check_all();
        logic [NB-1:0] exp_open;
        for (int i = 0; i < NB; i++) exp_open[i] = m_open[i];
        chk_eq("bank_open",  bank_open,  exp_open);
        chk_eq("err_valid",  err_valid,  m_ev);
        chk_eq("err_code",   err_code,   m_code);
        chk_eq("err_rank",   err_rank,   m_rank);
        chk_eq("err_bank",   err_bank,   m_bank);
        chk_eq("err_sticky", err_sticky, m_sticky);
        chk_eq("cnt_act",    cnt_act,    m_cnt[0]);
        chk_eq("cnt_rd",     cnt_rd,     m_cnt[1]);
        chk_eq("cnt_wr",     cnt_wr,     m_cnt[2]);
        chk_eq("cnt_ref",    cnt_ref,    m_cnt[3]);
    endtask

    task automatic set_cmd(input int kind, input int rank, input int bg, input int ba, input bit ap);
        ddr_addr = 18'($urandom);
        ddr_actn = 1'b1;
        ddr_cke  = 1'b1;
        ddr_csb  = '1;
        ddr_bg   = 2'(bg);
        ddr_ba   = 2'(ba);
        if (kind != K_DES) ddr_csb[rank] = 1'b0;
        case (kind)
            K_ACT:   ddr_actn = 1'b0;
            K_MRS:   ddr_addr[16:14] = 3'b000;
            K_REF:   ddr_addr[16:14] = 3'b001;
            K_PRE:   ddr_addr[16:14] = 3'b010;
            K_WR:    ddr_addr[16:14] = 3'b100;
            K_RD:    ddr_addr[16:14] = 3'b101;
            K_ZQC:   ddr_addr[16:14] = 3'b110;
            K_NOP:   ddr_addr[16:14] = 3'b111;
            K_RSVD:  ddr_addr[16:14] = 3'b011;
            default: ;
        endcase
        if (kind != K_ACT) ddr_addr[10] = ap;
    endtask

    // One clock: predict, let the edge happen, compare on the falling edge
    task automatic step();
        model_step();
        @(posedge ddr_ck);
        @(negedge ddr_ck);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_cmd(K_DES, 0, 0, 0, 1'b0);
            step();
        end
    endtask

    task automatic do_reset();
        ddr_rst = 1'b1;
        mon_en  = 1'b1;
        err_clr = 1'b0;
        set_cmd(K_DES, 0, 0, 0, 1'b0);
        model_reset();
        repeat (2) @(negedge ddr_ck);
        ddr_rst = 1'b0;
    endtask

    function automatic int pick_kind(input int sel);
        if (sel < 30) return K_DES;
        if (sel < 50) return K_ACT;
        if (sel < 65) return K_PRE;
        if (sel < 77) return K_RD;
        if (sel < 87) return K_WR;
        if (sel < 91) return K_REF;
        if (sel < 93) return K_MRS;
        if (sel < 95) return K_ZQC;
        if (sel < 97) return K_NOP;
        return K_RSVD;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish within time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        int save_act, save_rd, save_wr, save_ref;

        do_reset();
        chk_eq("rst_open",   bank_open,  '0);
        chk_eq("rst_valid",  err_valid,  1'b0);
        chk_eq("rst_code",   err_code,   4'd0);
        chk_eq("rst_sticky", err_sticky, 8'h00);
        chk_eq("rst_cnt",    {cnt_act, cnt_rd, cnt_wr, cnt_ref}, '0);

        // ACT r0 bg1 ba2, RD four cycles later is legal
        set_cmd(K_ACT, 0, 1, 2, 1'b0); step();
        idle(3);
        set_cmd(K_RD, 0, 1, 2, 1'b0); step();
        chk_eq("trcd_ok_open6", bank_open[6], 1'b1);
        chk_eq("trcd_ok_valid", err_valid, 1'b0);
        chk_eq("trcd_ok_act",   cnt_act, 4'd1);
        chk_eq("trcd_ok_rd",    cnt_rd, 4'd1);

        // Close legally, reopen, RD two cycles after ACT violates tRCD
        idle(10);
        set_cmd(K_PRE, 0, 1, 2, 1'b0); step();
        idle(3);
        set_cmd(K_ACT, 0, 1, 2, 1'b0); step();
        idle(1);
        set_cmd(K_RD, 0, 1, 2, 1'b0); step();
        chk_eq("trcd_err_valid", err_valid, 1'b1);
        chk_eq("trcd_err_code",  err_code, 4'd6);
        chk_eq("trcd_err_bank",  err_bank, 4'h6);
        idle(1);
        chk_eq("err_pulse_drop", err_valid, 1'b0);
        chk_eq("err_code_hold",  err_code, 4'd6);

        // Clear sticky, then tRAS and tRP violations on the same bank
        set_cmd(K_DES, 0, 0, 0, 1'b0); err_clr = 1'b1; step(); err_clr = 1'b0;
        chk_eq("clr_sticky", err_sticky, 8'h00);
        idle(8);
        set_cmd(K_PRE, 0, 1, 2, 1'b0); step();
        idle(3);
        set_cmd(K_ACT, 0, 1, 2, 1'b0); step();
        idle(4);
        set_cmd(K_PRE, 0, 1, 2, 1'b0); step();
        chk_eq("tras_code", err_code, 4'd7);
        idle(1);
        set_cmd(K_ACT, 0, 1, 2, 1'b0); step();
        chk_eq("trp_code",   err_code, 4'd4);
        chk_eq("trp_sticky", err_sticky, 8'h48);

        // Two chip selects low: code 1 only, no counting, no state change
        save_act = m_cnt[0]; save_rd = m_cnt[1]; save_wr = m_cnt[2]; save_ref = m_cnt[3];
        set_cmd(K_RSVD, 0, 0, 0, 1'b0); ddr_csb = 2'b00; step();
        chk_eq("mcs_code", err_code, 4'd1);
        set_cmd(K_ACT, 0, 0, 0, 1'b0); ddr_csb = 2'b00; step();
        chk_eq("mcs_open0",  bank_open[0], 1'b0);
        chk_eq("mcs_counts", {cnt_act, cnt_rd, cnt_wr, cnt_ref},
               {CNT_W'(save_act), CNT_W'(save_rd), CNT_W'(save_wr), CNT_W'(save_ref)});

        // Read counter saturation, then error wins over a concurrent clear
        for (int i = 0; i < 20; i++) begin
            set_cmd(K_RD, 0, 1, 2, 1'b0); step();
        end
        chk_eq("rd_saturate", cnt_rd, 4'hF);
        set_cmd(K_RSVD, 0, 0, 0, 1'b0); err_clr = 1'b1; step(); err_clr = 1'b0;
        chk_eq("clr_vs_err_sticky", err_sticky, 8'h02);

        // Asynchronous reset while err_valid is high
        set_cmd(K_RSVD, 1, 0, 0, 1'b0); step();
        #2 ddr_rst = 1'b1;
        #1;
        chk_eq("arst_valid", err_valid, 1'b0);
        chk_eq("arst_open",  bank_open, '0);
        chk_eq("arst_rd",    cnt_rd, 4'd0);
        chk_eq("arst_sticky", err_sticky, 8'h00);
        do_reset();

        // Randomized traffic over a few colliding banks on both ranks
        for (int n = 0; n < 1500; n++) begin
            if (n == 500 || n == 1000) do_reset();
            set_cmd(pick_kind($urandom_range(0, 99)), $urandom_range(0, NUM_RANKS - 1),
                    $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 39) == 0) ddr_csb = '0;
            mon_en  = ($urandom_range(0, 19) != 0);
            ddr_cke = ($urandom_range(0, 19) != 0);
            err_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
